counter_min_hour: RTL and testbench
===================================

COUNTER_MIN_HOUR -- requirements
Module: counter_min_hour

Interface
REQ-001 SHALL have parameter MIN_MAX, default 59, meaning the last minute value before wrap.
REQ-002 SHALL have parameter HOUR_MAX, default 23, meaning the last hour value before wrap (24-hour internal count).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port en, input, 1, count enable; low freezes the time.
REQ-006 SHALL have port minute_clk, input, 1, carry from the seconds stage, one or more cycles high per minute.
REQ-007 SHALL have port load, input, 1, time-set strobe, sampled each cycle.
REQ-008 SHALL have port set_min, input, 7, minute value to load.
REQ-009 SHALL have port set_hour, input, 5, hour value to load (0..HOUR_MAX).
REQ-010 SHALL have port mode_12h, input, 1, selects 12-hour display encoding.
REQ-011 SHALL have port minute_w, output, 7, current minute (0..MIN_MAX).
REQ-012 SHALL have port hour_w, output, 5, current hour, 24-hour (0..HOUR_MAX).
REQ-013 SHALL have port hour_disp, output, 5, display hour: hour_w if mode_12h=0, else 12-hour value.
REQ-014 SHALL have port pm, output, 1, high when hour_w >= 12 (regardless of mode_12h).
REQ-015 SHALL have port day_clk, output, 1, one-cycle pulse on wrap HOUR_MAX:MIN_MAX -> 0:0.
REQ-016 SHALL have port load_err, output, 1, one-cycle pulse when a load is rejected.

Function
REQ-017 SHALL register minute_clk into tick_d each cycle (including when en=0) and define tick = minute_clk & ~tick_d (rising edge).
REQ-018 SHALL advance the time exactly once per tick, on the same clk edge at which the tick is detected (one-edge latency from minute_clk rising).
REQ-019 SHALL increment minute_w when minute_w < MIN_MAX; else set minute_w = 0 and increment hour_w.
REQ-020 SHALL, when minute_w = MIN_MAX and hour_w = HOUR_MAX on a tick, set both to 0 and assert day_clk for that one cycle.
REQ-021 SHALL hold day_clk and load_err low in every cycle other than their defined pulse cycles.
REQ-022 SHALL apply priority per cycle: rst low > en low > load > tick.
REQ-023 SHALL, with en=0, hold minute_w and hour_w, ignore load and tick, and drive day_clk=0, load_err=0.
REQ-024 SHALL, on load with set_min <= MIN_MAX and set_hour <= HOUR_MAX, write both values on that edge; a tick in the same cycle is discarded.
REQ-025 SHALL, on load with either value out of range, leave minute_w/hour_w unchanged, pulse load_err one cycle, and discard a same-cycle tick.
REQ-026 SHALL not generate day_clk as a result of a load, even when loading 0:0.
REQ-027 SHALL not generate a tick on re-enable while minute_clk is already high (tick_d tracked during en=0).
REQ-028 SHALL compute hour_disp combinationally from hour_w: 0 -> 12, 1..12 -> same, 13..23 -> hour_w-12 when mode_12h=1.
REQ-029 SHALL treat minute_clk held high for multiple cycles as a single tick.
REQ-030 SHALL perform all arithmetic at output width with no overflow; values never leave 0..MIN_MAX / 0..HOUR_MAX.

Reset
REQ-031 SHALL, on a clk edge with rst=0, set minute_w=0, hour_w=0, tick_d=0, day_clk=0, load_err=0 (hence hour_disp=12 in 12h mode, pm=0).
REQ-032 SHALL give rst priority over en, load, and tick; reset mid-count discards any pending tick.
REQ-033 SHALL resume counting on the first tick after rst returns high; minute_clk high at release counts as a tick.

Verification
REQ-034 Reset, en=1, 60 minute_clk pulses (1 cycle each, 5 cycles apart) -> minute_w steps 0..59 then 0, hour_w=1, no day_clk.
REQ-035 Load 23:59, one tick -> minute_w=0, hour_w=0, day_clk high exactly one cycle on that edge.
REQ-036 Load 13:05 with mode_12h=1 -> hour_disp=1, pm=1; load 0:00 -> hour_disp=12, pm=0, no day_clk.
REQ-037 Load set_min=60 or set_hour=24 at 10:10 -> time stays 10:10, load_err one cycle; load and tick same cycle with valid 07:30 -> 07:30, tick lost.
REQ-038 minute_clk held high 10 cycles -> single increment; en=0 during a rising edge, en=1 while minute_clk still high -> no increment.
REQ-039 rst low for one cycle at 12:34 coincident with a tick -> 0:00 next cycle, day_clk=0, load_err=0.

Source files
------------

// File: rtl/counter_min_hour.sv
// counter_min_hour: minute/hour time-of-day counter with load, 12h display and day carry
module counter_min_hour #(
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       minute_clk,
  input  logic       load,
  input  logic [6:0] set_min,
  input  logic [4:0] set_hour,
  input  logic       mode_12h,
  output logic [6:0] minute_w,
  output logic [4:0] hour_w,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic       day_clk,
  output logic       load_err
);
  localparam logic [6:0] MIN_L  = 7'(MIN_MAX);
  localparam logic [4:0] HOUR_L = 5'(HOUR_MAX);
  logic tick_d;
  logic tick;
  logic load_ok;
  assign tick    = minute_clk & ~tick_d;
  assign load_ok = (set_min <= MIN_L) && (set_hour <= HOUR_L);
  // time state: reset > disable > load > tick; tick_d follows minute_clk even when disabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      minute_w <= '0;
      hour_w   <= '0;
      tick_d   <= 1'b0;
      day_clk  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick_d   <= minute_clk;
      day_clk  <= 1'b0;
      load_err <= 1'b0;
      if (en) begin
        if (load) begin
          if (load_ok) begin
            minute_w <= set_min;
            hour_w   <= set_hour;
          end else begin
            load_err <= 1'b1;
          end
        end else if (tick) begin
          if (minute_w < MIN_L) begin
            minute_w <= minute_w + 7'd1;
          end else begin
            minute_w <= '0;
            if (hour_w < HOUR_L) begin
              hour_w <= hour_w + 5'd1;
            end else begin
              hour_w  <= '0;
              day_clk <= 1'b1;
            end
          end
        end
      end
    end
  end
  // display encoding: midnight hour shows 12, afternoon hours fold down by 12
  always_comb begin
    pm        = hour_w >= 5'd12;
    hour_disp = !mode_12h ? hour_w :
                (hour_w == 5'd0) ? 5'd12 :
                (hour_w > 5'd12) ? hour_w - 5'd12 : hour_w;
  end
endmodule

// File: tb/tb_counter_min_hour.sv
// tb_counter_min_hour: directed self-checking bench for counter_min_hour
module tb_counter_min_hour;
  logic       clk = 1'b0;
  logic       rst, en, minute_clk, load, mode_12h;
  logic [6:0] set_min, minute_w;
  logic [4:0] set_hour, hour_w, hour_disp;
  logic       pm, day_clk, load_err;
  int errors = 0;
  int checks = 0;

  counter_min_hour dut (
    .clk(clk), .rst(rst), .en(en), .minute_clk(minute_clk), .load(load),
    .set_min(set_min), .set_hour(set_hour), .mode_12h(mode_12h),
    .minute_w(minute_w), .hour_w(hour_w), .hour_disp(hour_disp),
    .pm(pm), .day_clk(day_clk), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m);
    chk({tag, "_hour"}, 32'(hour_w), 32'(h));
    chk({tag, "_min"}, 32'(minute_w), 32'(m));
  endtask

  task automatic do_load(input int h, input int m);
    load = 1'b1;
    set_hour = 5'(h);
    set_min = 7'(m);
    step();
    load = 1'b0;
  endtask

  initial begin
    int day_seen;
    rst = 1'b0; en = 1'b1; minute_clk = 1'b0; load = 1'b0; mode_12h = 1'b1;
    set_min = '0; set_hour = '0;
    step(2);
    chk_time("reset", 0, 0);
    chk("reset_day", 32'(day_clk), 0);
    chk("reset_lerr", 32'(load_err), 0);
    chk("reset_disp", 32'(hour_disp), 12);
    chk("reset_pm", 32'(pm), 0);
    rst = 1'b1;
    mode_12h = 1'b0;
    step();
    chk_time("idle", 0, 0);

    day_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      minute_clk = 1'b1;
      step();
      chk("count_min", 32'(minute_w), 32'(i % 60));
      if (day_clk) day_seen++;
      minute_clk = 1'b0;
      step(4);
    end
    chk_time("hour_roll", 1, 0);
    chk("no_day_in_hour", 32'(day_seen), 0);

    do_load(23, 59);
    chk_time("load_2359", 23, 59);
    chk("load_no_day", 32'(day_clk), 0);
    minute_clk = 1'b1;
    step();
    chk_time("day_wrap", 0, 0);
    chk("day_pulse", 32'(day_clk), 1);
    minute_clk = 1'b0;
    step();
    chk("day_pulse_end", 32'(day_clk), 0);

    mode_12h = 1'b1;
    do_load(13, 5);
    chk("disp_13", 32'(hour_disp), 1);
    chk("pm_13", 32'(pm), 1);
    do_load(12, 0);
    chk("disp_12", 32'(hour_disp), 12);
    chk("pm_12", 32'(pm), 1);
    do_load(23, 0);
    chk("disp_23", 32'(hour_disp), 11);
    do_load(11, 0);
    chk("disp_11", 32'(hour_disp), 11);
    chk("pm_11", 32'(pm), 0);
    do_load(0, 0);
    chk("disp_0", 32'(hour_disp), 12);
    chk("pm_0", 32'(pm), 0);
    chk("load_00_no_day", 32'(day_clk), 0);
    mode_12h = 1'b0;
    do_load(23, 0);
    chk("disp_24h", 32'(hour_disp), 23);
    chk("pm_24h", 32'(pm), 1);

    do_load(10, 10);
    do_load(10, 60);
    chk_time("bad_min", 10, 10);
    chk("bad_min_err", 32'(load_err), 1);
    step();
    chk("err_end", 32'(load_err), 0);
    do_load(24, 10);
    chk_time("bad_hour", 10, 10);
    chk("bad_hour_err", 32'(load_err), 1);
    minute_clk = 1'b1;
    do_load(7, 30);
    chk_time("load_beats_tick", 7, 30);
    chk("good_load_no_err", 32'(load_err), 0);
    step();
    chk_time("tick_lost", 7, 30);
    minute_clk = 1'b0;
    step();

    minute_clk = 1'b1;
    step(10);
    minute_clk = 1'b0;
    step();
    chk_time("held_single", 7, 31);
    en = 1'b0;
    minute_clk = 1'b1;
    step();
    en = 1'b1;
    step(3);
    chk_time("reenable_high", 7, 31);
    minute_clk = 1'b0;
    step();
    en = 1'b0;
    do_load(1, 1);
    chk_time("en0_load", 7, 31);
    do_load(30, 1);
    chk("en0_no_err", 32'(load_err), 0);
    en = 1'b1;
    step();

    do_load(12, 34);
    minute_clk = 1'b1;
    rst = 1'b0;
    step();
    chk_time("rst_tick", 0, 0);
    chk("rst_day", 32'(day_clk), 0);
    chk("rst_lerr", 32'(load_err), 0);
    rst = 1'b1;
    step();
    chk_time("release_tick", 0, 1);
    minute_clk = 1'b0;
    step();
    chk_time("after_release", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
